// File: rtl/alu_pkg.sv
// alu_pkg: shared encodings for the execute unit.
//   - RV32 opcode constants (OP, OP-IMM, BRANCH, JALR)
//   - func3 values for the ALU, branch and M-extension groups
//   - func7 values (base, alternate, mul/div)
//   - FSM state enum and M-operation enum (M-op values equal func3)
package alu_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    // ALU group (OP / OP-IMM)
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    // Branch group
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Encoded so that mop_t'(func3) is the operation.
    typedef enum logic [2:0] {
        M_MUL    = 3'd0,
        M_MULH   = 3'd1,
        M_MULHSU = 3'd2,
        M_MULHU  = 3'd3,
        M_DIV    = 3'd4,
        M_DIVU   = 3'd5,
        M_REM    = 3'd6,
        M_REMU   = 3'd7
    } mop_t;

endpackage

// File: rtl/mdu_iter.sv
// mdu_iter: iterative multiply / divide datapath, one bit per step.
//   clk, rst : clock, async active-high reset (clears accumulators)
//   start    : load operands (magnitudes) and operation
//   step     : advance one iteration
//   op       : M operation, sampled on start
//   a, b     : operands, sampled on start
//   result   : final value as it will be after the current step; the
//              caller samples it on the edge that performs the last step.
// The 2*XLEN accumulator holds {high, low}. Multiply shifts right,
// adding the multiplicand into the high half when low[0] is set.
// Divide shifts left (restoring), high half = partial remainder,
// low half = dividend shifting out / quotient shifting in.
module mdu_iter
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            step,
    input  mop_t            op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] result
);

    logic [2*XLEN-1:0] acc;
    logic [2*XLEN-1:0] acc_n;
    logic [XLEN-1:0]   opnd;      // multiplicand or divisor magnitude
    logic              is_div;
    logic              want_hi;   // mulh/mulhsu/mulhu
    logic              want_rem;  // rem/remu
    logic              neg_res;   // product / quotient sign
    logic              neg_rem;   // remainder follows dividend

    logic              a_neg;
    logic              b_neg;
    logic [XLEN-1:0]   a_mag;
    logic [XLEN-1:0]   b_mag;

    always_comb begin
        a_neg = a[XLEN-1] && (op == M_MULH || op == M_MULHSU || op == M_DIV || op == M_REM);
        b_neg = b[XLEN-1] && (op == M_MULH || op == M_DIV || op == M_REM);
        a_mag = a_neg ? -a : a;
        b_mag = b_neg ? -b : b;
    end

    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   div_diff;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0] quo;
    logic [XLEN-1:0] rem;

    always_comb begin
        hi       = acc[2*XLEN-1:XLEN];
        lo       = acc[XLEN-1:0];
        mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
        div_diff = {hi, lo[XLEN-1]} - {1'b0, opnd};
        if (is_div) begin
            // div_diff[XLEN] set means the shifted remainder was below the divisor
            if (div_diff[XLEN]) begin
                acc_n = {hi[XLEN-2:0], lo[XLEN-1], lo[XLEN-2:0], 1'b0};
            end else begin
                acc_n = {div_diff[XLEN-1:0], lo[XLEN-2:0], 1'b1};
            end
        end else begin
            acc_n = {mul_sum, lo[XLEN-1:1]};
        end

        prod = neg_res ? -acc_n : acc_n;
        quo  = neg_res ? -acc_n[XLEN-1:0] : acc_n[XLEN-1:0];
        rem  = neg_rem ? -acc_n[2*XLEN-1:XLEN] : acc_n[2*XLEN-1:XLEN];

        if (is_div) begin
            result = want_rem ? rem : quo;
        end else begin
            result = want_hi ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc      <= '0;
            opnd     <= '0;
            is_div   <= 1'b0;
            want_hi  <= 1'b0;
            want_rem <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
        end else if (start) begin
            acc      <= {{XLEN{1'b0}}, a_mag};
            opnd     <= b_mag;
            is_div   <= op[2];
            want_hi  <= (op != M_MUL);
            want_rem <= op[1];
            neg_res  <= a_neg ^ b_neg;
            neg_rem  <= a_neg;
        end else if (step) begin
            acc      <= acc_n;
        end
    end

endmodule

// File: rtl/alu_mdu.sv
// alu_mdu: handshaked execute unit (RV32I ALU/branch/JALR + RV32M).
//   clk, rst              : clock, async active-high reset
//   in_valid / in_ready   : request handshake; in_ready high only in IDLE
//   opcode, func3, func7  : instruction fields, captured on acceptance
//   op1, op2              : operands (op2 = immediate for OP-IMM/JALR)
//   out_valid / out_ready : result handshake; outputs held while waiting
//   result, branch_taken  : registered results
//   fsm_state             : current FSM state for observation
// Handshake: a transfer happens on a rising edge where valid && ready.
// Single-cycle ops and M special cases go IDLE->DONE; other M ops go
// IDLE->CALC for XLEN steps of mdu_iter, then DONE.
module alu_mdu
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [6:0]      opcode,
    input  logic [2:0]      func3,
    input  logic [6:0]      func7,
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            branch_taken,
    output state_t          fsm_state
);

    localparam int CW = $clog2(XLEN);

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [XLEN-1:0] result_n;
    logic            taken_n;

    // ---- decode and single-cycle datapath (live inputs, used in IDLE) ----
    logic [CW-1:0]   shamt;
    logic            alt;
    logic [XLEN-1:0] sum, diff, base_val, alu_val;
    logic            lt_s, lt_u, alu_taken, m_iter;
    logic            div_zero, div_ovf;

    always_comb begin
        shamt    = op2[CW-1:0];
        alt      = func7[5];
        sum      = op1 + op2;
        diff     = op1 - op2;
        lt_s     = $signed(op1) < $signed(op2);
        lt_u     = op1 < op2;
        div_zero = (op2 == '0);
        div_ovf  = (op1 == {1'b1, {(XLEN-1){1'b0}}}) && (op2 == '1);

        base_val = '0;
        case (func3)
            F3_ADD:  base_val = (opcode == OPC_OP && alt) ? diff : sum;
            F3_SLL:  base_val = op1 << shamt;
            F3_SLT:  base_val = {{(XLEN-1){1'b0}}, lt_s};
            F3_SLTU: base_val = {{(XLEN-1){1'b0}}, lt_u};
            F3_XOR:  base_val = op1 ^ op2;
            F3_SR: begin
                if (alt) base_val = $signed(op1) >>> shamt;
                else     base_val = op1 >> shamt;
            end
            F3_OR:   base_val = op1 | op2;
            default: base_val = op1 & op2;
        endcase

        alu_val   = '0;
        alu_taken = 1'b0;
        m_iter    = 1'b0;
        case (opcode)
            OPC_OP: begin
                if (func7 == F7_BASE || func7 == F7_ALT) begin
                    alu_val = base_val;
                end else if (func7 == F7_MULDIV) begin
                    // Division special cases finish without iterating.
                    case (mop_t'(func3))
                        M_DIV: begin
                            if (div_zero)     alu_val = '1;
                            else if (div_ovf) alu_val = op1;
                            else              m_iter  = 1'b1;
                        end
                        M_DIVU: begin
                            if (div_zero) alu_val = '1;
                            else          m_iter  = 1'b1;
                        end
                        M_REM: begin
                            if (div_zero)     alu_val = op1;
                            else if (div_ovf) alu_val = '0;
                            else              m_iter  = 1'b1;
                        end
                        M_REMU: begin
                            if (div_zero) alu_val = op1;
                            else          m_iter  = 1'b1;
                        end
                        default: m_iter = 1'b1;
                    endcase
                end
            end
            OPC_OP_IMM: alu_val = base_val;
            OPC_BRANCH: begin
                if (func3 != 3'b010 && func3 != 3'b011) begin
                    alu_val = diff;
                    case (func3)
                        F3_BEQ:  alu_taken = (op1 == op2);
                        F3_BNE:  alu_taken = (op1 != op2);
                        F3_BLT:  alu_taken = lt_s;
                        F3_BGE:  alu_taken = !lt_s;
                        F3_BLTU: alu_taken = lt_u;
                        default: alu_taken = !lt_u;
                    endcase
                end
            end
            OPC_JALR: alu_val = {sum[XLEN-1:1], 1'b0};
            default: ;
        endcase
    end

    // ---- iterative multiply/divide ----
    logic            mdu_start;
    logic            mdu_step;
    logic [XLEN-1:0] mdu_result;

    assign mdu_start = (state == ST_IDLE) && in_valid && m_iter;
    assign mdu_step  = (state == ST_CALC);

    mdu_iter #(.XLEN(XLEN)) u_mdu (
        .clk    (clk),
        .rst    (rst),
        .start  (mdu_start),
        .step   (mdu_step),
        .op     (mop_t'(func3)),
        .a      (op1),
        .b      (op2),
        .result (mdu_result)
    );

    // ---- FSM ----
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        result_n = result;
        taken_n  = branch_taken;
        case (state)
            ST_IDLE: begin
                if (in_valid) begin
                    if (m_iter) begin
                        state_n = ST_CALC;
                        cnt_n   = CW'(XLEN - 1);
                        taken_n = 1'b0;
                    end else begin
                        state_n  = ST_DONE;
                        result_n = alu_val;
                        taken_n  = alu_taken;
                    end
                end
            end
            ST_CALC: begin
                if (cnt == '0) begin
                    // This edge performs the final step; capture its outcome.
                    state_n  = ST_DONE;
                    result_n = mdu_result;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            ST_DONE: begin
                if (out_ready) state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            result       <= '0;
            branch_taken <= 1'b0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            result       <= result_n;
            branch_taken <= taken_n;
        end
    end

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign fsm_state = state;

endmodule

// File: tb/tb_alu_mdu.sv
// tb_alu_mdu: self-checking bench for alu_mdu (XLEN = 32).
// Expected {branch_taken, result} values are pushed to exp_q when a
// request is driven and popped when out_valid is observed.
module tb_alu_mdu;
    import alu_pkg::*;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [6:0]      opcode;
    logic [2:0]      func3;
    logic [6:0]      func7;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            branch_taken;
    state_t          fsm_state;

    logic [XLEN:0] exp_q[$];
    int vectors     = 0;
    int miscompares = 0;

    alu_mdu #(.XLEN(XLEN)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .opcode       (opcode),
        .func3        (func3),
        .func7        (func7),
        .op1          (op1),
        .op2          (op2),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .result       (result),
        .branch_taken (branch_taken),
        .fsm_state    (fsm_state)
    );

    // ---- clock / watchdog ----
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---- checker ----
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---- reference model: returns {taken, result} ----
    function automatic logic [XLEN:0] model(input logic [6:0] opc, input logic [2:0] f3,
                                            input logic [6:0] f7, input logic [31:0] a,
                                            input logic [31:0] b);
        logic signed [63:0] sa, sb, p;
        logic [63:0] ua, ub, pu;
        logic [31:0] r;
        logic t;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'b0, a};
        ub = {32'b0, b};
        r  = '0;
        t  = 1'b0;
        if (opc == 7'b0110011 && f7 == 7'h01) begin
            case (f3)
                3'd0: r = a * b;
                3'd1: begin p = sa * sb; r = p[63:32]; end
                3'd2: begin p = sa * $signed(ub); r = p[63:32]; end
                3'd3: begin pu = ua * ub; r = pu[63:32]; end
                3'd4: begin
                    if (b == 0) r = 32'hFFFFFFFF;
                    else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = a;
                    else r = $signed(a) / $signed(b);
                end
                3'd5: begin
                    if (b == 0) r = 32'hFFFFFFFF;
                    else r = a / b;
                end
                3'd6: begin
                    if (b == 0) r = a;
                    else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = 0;
                    else r = $signed(a) % $signed(b);
                end
                default: begin
                    if (b == 0) r = a;
                    else r = a % b;
                end
            endcase
        end else if ((opc == 7'b0110011 && (f7 == 7'h00 || f7 == 7'h20)) || opc == 7'b0010011) begin
            case (f3)
                3'd0: begin
                    if (opc == 7'b0110011 && f7[5]) r = a - b;
                    else r = a + b;
                end
                3'd1: r = a << b[4:0];
                3'd2: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                3'd3: r = (a < b) ? 32'd1 : 32'd0;
                3'd4: r = a ^ b;
                3'd5: begin
                    if (f7[5]) r = $signed(a) >>> b[4:0];
                    else r = a >> b[4:0];
                end
                3'd6: r = a | b;
                default: r = a & b;
            endcase
        end else if (opc == 7'b1100011 && f3 != 3'd2 && f3 != 3'd3) begin
            r = a - b;
            case (f3)
                3'd0: t = (a == b);
                3'd1: t = (a != b);
                3'd4: t = ($signed(a) < $signed(b));
                3'd5: t = !($signed(a) < $signed(b));
                3'd6: t = (a < b);
                default: t = !(a < b);
            endcase
        end else if (opc == 7'b1100111) begin
            r = (a + b) & 32'hFFFFFFFE;
        end
        return {t, r};
    endfunction

    function automatic int model_lat(input logic [6:0] opc, input logic [2:0] f3,
                                     input logic [6:0] f7, input logic [31:0] a,
                                     input logic [31:0] b);
        if (opc != 7'b0110011 || f7 != 7'h01) return 1;
        if (f3[2] && b == 0) return 1;
        if (f3[2] && !f3[0] && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
        return XLEN + 1;
    endfunction

    // ---- driver: one request through to its result handshake ----
    task automatic issue(input string tag, input logic [6:0] opc, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b,
                         input logic [XLEN:0] exp, input int exp_lat, input int hold,
                         input bit pre_ready);
        int lat;
        logic [XLEN:0] want;
        @(negedge clk);
        check({tag, ".in_ready"}, 64'(in_ready), 64'd1);
        opcode   = opc;
        func3    = f3;
        func7    = f7;
        op1      = a;
        op2      = b;
        in_valid = 1'b1;
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        // Scramble inputs: the captured request must not be affected.
        in_valid  = 1'b0;
        opcode    = 7'($urandom);
        func3     = 3'($urandom);
        func7     = 7'($urandom);
        op1       = $urandom;
        op2       = $urandom;
        out_ready = pre_ready;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        out_ready = 1'b0;
        want = exp_q.pop_front();
        if (!out_valid) begin
            check({tag, ".timeout"}, 64'(out_valid), 64'd1);
            return;
        end
        check({tag, ".latency"}, 64'(lat), 64'(exp_lat));
        check({tag, ".result"}, 64'({branch_taken, result}), 64'(want));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check({tag, ".held"}, 64'({out_valid, branch_taken, result}), 64'({1'b1, want}));
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, ".release"}, 64'({in_ready, out_valid}), 64'b10);
    endtask

    task automatic issue_rand(input int n);
        logic [6:0] opc, f7;
        logic [2:0] f3;
        logic [31:0] a, b;
        for (int i = 0; i < n; i++) begin
            a  = $urandom;
            b  = $urandom;
            f3 = 3'($urandom_range(0, 7));
            f7 = 7'h00;
            case ($urandom_range(0, 3))
                0: begin opc = OPC_OP; f7 = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00; end
                1: begin opc = OPC_OP_IMM; if (f3 == 3'd5 && $urandom_range(0, 1) == 1) f7 = 7'h20; end
                2: begin opc = OPC_BRANCH; if (f3 == 3'd2 || f3 == 3'd3) f3 = 3'd4; end
                default: begin
                    opc = OPC_OP;
                    f7  = 7'h01;
                    if ($urandom_range(0, 4) == 0) b = 0;
                    if ($urandom_range(0, 3) == 0) a = a >> $urandom_range(0, 31);
                end
            endcase
            if (opc == OPC_OP || opc == OPC_OP_IMM) begin
                if (f3 == 3'd1 || f3 == 3'd5) b = b & 32'h41F;
            end
            issue("rand", opc, f3, f7, a, b, model(opc, f3, f7, a, b),
                  model_lat(opc, f3, f7, a, b), $urandom_range(0, 2), 1'b1);
        end
    endtask

    // ---- main sequence ----
    initial begin
        int rose;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        opcode    = '0;
        func3     = '0;
        func7     = '0;
        op1       = '0;
        op2       = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset.outputs", 64'({in_ready, out_valid, branch_taken, result}),
              64'({1'b1, 1'b0, 1'b0, 32'h0}));
        check("reset.state", 64'(fsm_state), 64'(ST_IDLE));
        @(negedge clk);
        rst = 1'b0;

        issue("add", OPC_OP, F3_ADD, F7_BASE, 32'd7, 32'd5, {1'b0, 32'd12}, 1, 3, 1'b0);
        issue("sra", OPC_OP, F3_SR, F7_ALT, 32'h80000000, 32'd4, {1'b0, 32'hF8000000}, 1, 0, 1'b0);
        issue("srl", OPC_OP, F3_SR, F7_BASE, 32'h80000000, 32'd4, {1'b0, 32'h08000000}, 1, 0, 1'b0);
        issue("srai", OPC_OP_IMM, F3_SR, F7_ALT, 32'h80000000, 32'h404, {1'b0, 32'hF8000000}, 1, 0, 1'b0);
        issue("sub", OPC_OP, F3_ADD, F7_ALT, 32'd5, 32'd7, {1'b0, 32'hFFFFFFFE}, 1, 0, 1'b0);

        issue("mul", OPC_OP, 3'd0, F7_MULDIV, 32'hFFFFFFFE, 32'd3, {1'b0, 32'hFFFFFFFA}, 33, 1, 1'b1);
        issue("mulh", OPC_OP, 3'd1, F7_MULDIV, 32'hFFFFFFFE, 32'd3, {1'b0, 32'hFFFFFFFF}, 33, 0, 1'b0);
        issue("mulhu", OPC_OP, 3'd3, F7_MULDIV, 32'hFFFFFFFF, 32'd2, {1'b0, 32'h00000001}, 33, 0, 1'b0);
        issue("mulhsu", OPC_OP, 3'd2, F7_MULDIV, 32'hFFFFFFFF, 32'hFFFFFFFF, {1'b0, 32'hFFFFFFFF}, 33, 0, 1'b0);

        issue("div0", OPC_OP, 3'd4, F7_MULDIV, 32'd100, 32'd0, {1'b0, 32'hFFFFFFFF}, 1, 0, 1'b0);
        issue("rem0", OPC_OP, 3'd6, F7_MULDIV, 32'd100, 32'd0, {1'b0, 32'd100}, 1, 0, 1'b0);
        issue("divu", OPC_OP, 3'd5, F7_MULDIV, 32'hFFFFFFF9, 32'd2, {1'b0, 32'h7FFFFFFC}, 33, 0, 1'b0);
        issue("div_ovf", OPC_OP, 3'd4, F7_MULDIV, 32'h80000000, 32'hFFFFFFFF, {1'b0, 32'h80000000}, 1, 0, 1'b0);
        issue("rem_ovf", OPC_OP, 3'd6, F7_MULDIV, 32'h80000000, 32'hFFFFFFFF, {1'b0, 32'h0}, 1, 0, 1'b0);
        issue("div", OPC_OP, 3'd4, F7_MULDIV, 32'hFFFFFFF9, 32'd2, {1'b0, 32'hFFFFFFFD}, 33, 0, 1'b0);
        issue("rem", OPC_OP, 3'd6, F7_MULDIV, 32'hFFFFFFF9, 32'd2, {1'b0, 32'hFFFFFFFF}, 33, 0, 1'b0);

        issue("blt", OPC_BRANCH, F3_BLT, F7_BASE, 32'hFFFFFFFF, 32'd1, {1'b1, 32'hFFFFFFFE}, 1, 0, 1'b0);
        issue("bltu", OPC_BRANCH, F3_BLTU, F7_BASE, 32'hFFFFFFFF, 32'd1, {1'b0, 32'hFFFFFFFE}, 1, 0, 1'b0);
        issue("beq", OPC_BRANCH, F3_BEQ, F7_BASE, 32'd5, 32'd5, {1'b1, 32'd0}, 1, 0, 1'b0);
        issue("jalr", OPC_JALR, 3'd0, F7_BASE, 32'h1001, 32'd2, {1'b0, 32'h1002}, 1, 0, 1'b0);
        issue("bad_opc", 7'h7F, 3'd0, F7_BASE, 32'd3, 32'd4, {1'b0, 32'd0}, 1, 0, 1'b0);
        issue("bad_br", OPC_BRANCH, 3'd2, F7_BASE, 32'd3, 32'd3, {1'b0, 32'd0}, 1, 0, 1'b0);
        issue("bad_f7", OPC_OP, F3_ADD, 7'h10, 32'd3, 32'd4, {1'b0, 32'd0}, 1, 0, 1'b0);

        issue_rand(24);

        // Reset during an iterative divu: the operation must vanish.
        @(negedge clk);
        opcode   = OPC_OP;
        func3    = 3'd5;
        func7    = F7_MULDIV;
        op1      = 32'hFFFFFFF9;
        op2      = 32'd2;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("rst.during", 64'({in_ready, out_valid}), 64'b10);
        repeat (2) @(posedge clk);
        #1;
        check("rst.held", 64'({in_ready, out_valid, result}), 64'({2'b10, 32'h0}));
        @(negedge clk);
        rst  = 1'b0;
        rose = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) rose = 1;
        end
        check("rst.no_valid", 64'(rose), 64'd0);
        check("rst.after", 64'(in_ready), 64'd1);
        issue("add_after_rst", OPC_OP, F3_ADD, F7_BASE, 32'd1, 32'd1, {1'b0, 32'd2}, 1, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
